// File: rtl/e_mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
// Holds the MDU operation codes, default busy durations and the
// value driven on the read port when no mfhi/mflo is in progress.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mthi  = 4'd5,
        MDU_mtlo  = 4'd6,
        MDU_mfhi  = 4'd7,
        MDU_mflo  = 4'd8
    } mdu_op_e;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;
    localparam logic [31:0] MDU_DEFAULT         = 32'h0;

    function automatic logic is_mul(input mdu_op_e op);
        return (op == MDU_mult) || (op == MDU_multu);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   op          operation code
//   src_a/src_b rs/rt operands
//   hi/lo       current architectural HI/LO
//   hi_t/lo_t   result to stage; equals hi/lo for non-arithmetic ops
//               and for divide by zero, so the later write-back is a no-op
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_t,
    output logic [31:0] lo_t
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo_m;
    logic [31:0] rem_m;
    logic [31:0] safe_b;

    always_comb begin
        prod_u = {32'h0, src_a} * {32'h0, src_b};
        prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};

        // Divisor forced non-zero so the dividers never see 0; the
        // divide-by-zero result is discarded below anyway.
        safe_b = (src_b == '0) ? 32'd1 : src_b;
        quo_u  = src_a / safe_b;
        rem_u  = src_a % safe_b;

        // Signed divide on magnitudes: 0x80000000 / -1 wraps back to
        // 0x80000000 after re-negation, with remainder 0.
        neg_a = src_a[31];
        neg_b = safe_b[31];
        mag_a = neg_a ? -src_a : src_a;
        mag_b = neg_b ? -safe_b : safe_b;
        quo_m = mag_a / mag_b;
        rem_m = mag_a % mag_b;

        hi_t = hi;
        lo_t = lo;
        case (op)
            MDU_mult:  {hi_t, lo_t} = prod_s;
            MDU_multu: {hi_t, lo_t} = prod_u;
            MDU_div: begin
                if (src_b != '0) begin
                    lo_t = (neg_a ^ neg_b) ? -quo_m : quo_m;
                    hi_t = neg_a ? -rem_m : rem_m;
                end
            end
            MDU_divu: begin
                if (src_b != '0) begin
                    lo_t = quo_u;
                    hi_t = rem_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_req           flush of the E-stage instruction (blocks start, mthi/mtlo)
//   i_mduOp         MDU operation code
//   i_start         E-stage instruction is mult/multu/div/divu
//   i_srcA, i_srcB  forwarded rs/rt operands
//   o_busy          an operation is in flight
//   o_result        HI for mfhi, LO for mflo, else 0
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [3:0]  i_mduOp,
    input  logic        i_start,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    output logic        o_busy,
    output logic [31:0] o_result
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e      state;
    mdu_op_e     op;
    logic [3:0]  count;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hi_t;
    logic [31:0] lo_t;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;

    always_comb op = mdu_op_e'(i_mduOp);

    e_mdu_calc u_calc (
        .op    (op),
        .src_a (i_srcA),
        .src_b (i_srcB),
        .hi    (hi),
        .lo    (lo),
        .hi_t  (calc_hi),
        .lo_t  (calc_lo)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_t   <= '0;
            lo_t   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_req) begin
                        if (i_start && (is_mul(op) || is_div(op))) begin
                            hi_t   <= calc_hi;
                            lo_t   <= calc_lo;
                            count  <= is_mul(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            state  <= BUSY;
                            o_busy <= 1'b1;
                        end else if (op == MDU_mthi) begin
                            hi <= i_srcA;
                        end else if (op == MDU_mtlo) begin
                            lo <= i_srcA;
                        end
                    end
                end
                BUSY: begin
                    // i_req is ignored here: the in-flight op is already committed.
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        hi     <= hi_t;
                        lo     <= lo_t;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (op)
            MDU_mfhi: o_result = hi;
            MDU_mflo: o_result = lo;
            default:  o_result = MDU_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req;
    logic [3:0]  op;
    logic        start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    // Behavioural model state: architectural HI/LO, pending result and
    // the number of busy cycles still to run.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_req    (req),
        .i_mduOp  (op),
        .i_start  (start),
        .i_srcA   (src_a),
        .i_srcB   (src_b),
        .o_busy   (busy),
        .o_result (result)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void model_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                       output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, ps, q, r;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        h = cur_hi;
        l = cur_lo;
        if (o == MDU_mult) begin
            ps = sa * sb;
            h = ps[63:32]; l = ps[31:0];
        end else if (o == MDU_multu) begin
            pu = ua * ub;
            h = pu[63:32]; l = pu[31:0];
        end else if (o == MDU_div && b != 0) begin
            q = sa / sb; r = sa % sb;
            h = r[31:0]; l = q[31:0];
        end else if (o == MDU_divu && b != 0) begin
            q = longint'(ua / ub); r = longint'(ua % ub);
            h = r[31:0]; l = q[31:0];
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (chk_on && (start || op == MDU_mthi || op == MDU_mtlo)) begin
                n_checks++;
                n_fail++;
                $display("FAIL hazard_contract: op=%0d start=%0b issued while busy, required none", op, start);
            end
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (!req) begin
            if (start && (op == MDU_mult || op == MDU_multu)) begin
                model_calc(op, src_a, src_b, m_hi, m_lo, p_hi, p_lo);
                m_left = 5;
            end else if (start && (op == MDU_div || op == MDU_divu)) begin
                model_calc(op, src_a, src_b, m_hi, m_lo, p_hi, p_lo);
                m_left = 10;
            end else if (op == MDU_mthi) begin
                m_hi = src_a;
            end else if (op == MDU_mtlo) begin
                m_lo = src_a;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [31:0] exp_res;
        if (chk_on && !rst) begin
            exp_res = (op == MDU_mfhi) ? m_hi : (op == MDU_mflo) ? m_lo : 32'h0;
            n_checks++;
            if (busy !== (m_left > 0)) begin
                n_fail++;
                $display("FAIL busy_model: got=%0b exp=%0b t=%0t", busy, (m_left > 0), $time);
            end
            n_checks++;
            if (result !== exp_res) begin
                n_fail++;
                $display("FAIL result_model: op=%0d got=%h exp=%h t=%0t", op, result, exp_res, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic q, input logic [3:0] o, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        rst = r; req = q; op = o; start = s; src_a = a; src_b = b;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic peek(input logic [3:0] o, output logic [31:0] v);
        op = o; start = 0;
        #1;
        v = result;
        op = MDU_none;
    endtask

    task automatic chk_hl(input string name, input logic [31:0] h, input logic [31:0] l);
        logic [31:0] v;
        peek(MDU_mfhi, v); chk({name, "_hi"}, v, h);
        peek(MDU_mflo, v); chk({name, "_lo"}, v, l);
    endtask

    // Issue one start and confirm busy spans exactly n cycles.
    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] lo_during);
        logic [31:0] v;
        set_in(0, 0, o, 1, a, b);
        tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        for (int i = 1; i <= n; i++) begin
            chk({name, "_busy"}, {31'h0, busy}, 32'h1);
            if (i == 2) begin
                peek(MDU_mflo, v);
                chk({name, "_old_lo"}, v, lo_during);
            end
            tick();
        end
        chk({name, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [3:0] ro;
        set_in(1, 0, MDU_none, 0, 0, 0);
        tick();
        tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        chk_on = 1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk_hl("reset", 32'h0, 32'h0);

        run_op("mult", MDU_mult, 32'hFFFF_FFFF, 32'd2, 5, 32'h0);
        chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op("multu", MDU_multu, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFE);
        chk_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div", MDU_div, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFE);
        chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu", MDU_divu, 32'd7, 32'd2, 10, 32'hFFFF_FFFD);
        chk_hl("divu", 32'h1, 32'h3);

        set_in(0, 0, MDU_mthi, 0, 32'h1234, 0); tick();
        set_in(0, 0, MDU_mtlo, 0, 32'h5678, 0); tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        chk_hl("mthi_mtlo", 32'h1234, 32'h5678);
        run_op("divu0", MDU_divu, 32'd7, 32'd0, 10, 32'h5678);
        chk_hl("divu0", 32'h1234, 32'h5678);

        set_in(0, 1, MDU_mult, 1, 32'h3, 32'h5); tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        chk("req_start_busy", {31'h0, busy}, 32'h0);
        chk_hl("req_start", 32'h1234, 32'h5678);
        set_in(0, 1, MDU_mtlo, 0, 32'hAA, 0); tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        chk_hl("req_mtlo", 32'h1234, 32'h5678);

        run_op("div_ovf", MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h5678);
        chk_hl("div_ovf", 32'h0, 32'h8000_0000);

        set_in(0, 0, MDU_mtlo, 0, 32'h99, 0); tick();
        set_in(0, 0, MDU_div, 1, 32'd100, 32'd7); tick();
        set_in(0, 0, MDU_none, 0, 0, 0);
        tick(); tick(); tick();
        rst = 1; tick();
        rst = 0;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk_hl("rst_mid", 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst_after_busy", {31'h0, busy}, 32'h0);
        chk_hl("rst_after", 32'h0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                set_in(1, 0, MDU_none, 0, rnd_val(), rnd_val());
            end else if (m_left > 0) begin
                case ($urandom_range(0, 2))
                    0:       ro = MDU_none;
                    1:       ro = MDU_mfhi;
                    default: ro = MDU_mflo;
                endcase
                set_in(0, $urandom_range(0, 3) == 0, ro, 0, rnd_val(), rnd_val());
            end else begin
                ro = 4'($urandom_range(0, 8));
                set_in(0, $urandom_range(0, 7) == 0, ro,
                       (ro == MDU_mult || ro == MDU_multu || ro == MDU_div || ro == MDU_divu),
                       rnd_val(), rnd_val());
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
